cpld_reg_arbiter: RTL
=====================

Name: cpld_reg_arbiter

Overview:
- Shares the single CPLD register-map access port (DevAddr / RdDev_En / WrDev_En / WrDev_Data / RdDev_Data) between two requesters.
- Requester 0 is the LPC I/O decode path. Requester 1 is the BMC mailbox / SMBus slave path.
- Sequences one read or write per grant with a fixed 4-cycle transaction and round-robin (or fixed) arbitration.
- Blocks requester-1 writes to BIOS-owned offsets (0x01 watchdog control, 0x04 BIOS status).

Parameters:
- FIXED_PRIO, 0, 1 = requester 0 always wins a tie; 0 = round-robin.
- IO_BASE_HI, 8'h00, value driven on DevAddr[15:8].
- BMC_WP_MASK, 32'h0000_0012, bit n set = requester 1 may not write offset n (offsets 0x00–0x1F).

Ports:
- Mclk  in  1  register-map clock (LPC 33 MHz).
- MainReset  in  1  asynchronous, active-high reset.
- Req0  in  1  requester 0 transaction request (level).
- Wr0  in  1  requester 0: 1 = write, 0 = read.
- Addr0  in  8  requester 0 register offset.
- WData0  in  8  requester 0 write data.
- Ack0  out  1  requester 0 completion pulse.
- RData0  out  8  requester 0 read data.
- Req1, Wr1, Addr1, WData1  in  1/1/8/8  requester 1, same meaning as requester 0.
- Ack1  out  1  requester 1 completion pulse.
- RData1  out  8  requester 1 read data.
- Err1  out  1  pulses with Ack1 when a requester-1 write was blocked.
- Busy  out  1  high whenever the FSM is not in IDLE.
- DevAddr  out  16  to register map.
- RdDev_En  out  1  to register map.
- WrDev_En  out  1  to register map.
- WrDev_Data  out  8  to register map.
- RdDev_Data  in  8  from register map; valid the cycle after RdDev_En.

Behaviour:
- Reset values (async, while MainReset=1):
  - FSM in IDLE.
  - Ack0=Ack1=Err1=Busy=0.
  - RData0=RData1=8'hFF.
  - DevAddr={IO_BASE_HI,8'h00}.
  - RdDev_En=WrDev_En=0, WrDev_Data=8'h00.
  - LastGnt=1, so requester 0 wins the first tie.
- All outputs are registered.
- FSM states: IDLE -> ISSUE -> CAPT -> ACK -> IDLE. Every transaction takes exactly 4 cycles from the IDLE sample.
- IDLE:
  - Samples Req0/Req1.
  - If none is set, stays in IDLE.
  - Otherwise selects Gnt:
    - Only one request: that requester.
    - Both, FIXED_PRIO=1: requester 0.
    - Both, FIXED_PRIO=0: the requester other than LastGnt.
  - Latches Gnt's Wr, Addr, WData into internal registers. Updates LastGnt=Gnt. Goes to ISSUE.
- ISSUE (one cycle):
  - DevAddr={IO_BASE_HI, latched addr}.
  - Read: RdDev_En=1.
  - Write: WrDev_En=1 and WrDev_Data=latched data, unless blocked.
  - Blocked = Gnt=1 and write and latched addr[7:5]==0 and BMC_WP_MASK[addr[4:0]]=1. A blocked write drives no enable and sets the internal Err flag.
  - Offsets above 0x1F are passed through unchanged; the register map returns 8'hFF on read and ignores the write.
- CAPT:
  - Enables return to 0.
  - On a read, RdDev_Data is captured into RData of Gnt. The other requester's RData holds.
  - On a write, RData is unchanged.
- ACK:
  - Ack of Gnt =1 for exactly one cycle.
  - Err1=1 in the same cycle if Gnt=1 and the write was blocked; Err clears on leaving ACK.
  - Returns to IDLE.
- Requester rule: Req must be low, or carry a new transaction, in the cycle after its Ack. Req held high is treated as a back-to-back request, 4-cycle period.
- Req/Addr/Wr/WData changes after the IDLE sample have no effect on the transaction in flight.
- Round-robin: both Req held high alternate grants 0,1,0,1…; neither requester waits longer than one transaction.
- RdDev_En and WrDev_En are never both 1. Neither is 1 outside ISSUE.
- Reset mid-transaction: the transaction is abandoned, no Ack is issued, all outputs return to reset values, LastGnt=1.

Test Plan:
- Req0 read offset 0x00 after reset:
  - ISSUE cycle shows RdDev_En=1, DevAddr=16'h0000.
  - Ack0 asserts exactly 3 cycles after the IDLE sample.
  - RData0 = version byte.
  - RData1 stays 8'hFF.
- Req1 write 0x3C to offset 0x05, then Req1 read 0x05:
  - WrDev_En=1 for one cycle with WrDev_Data=8'h3C.
  - Ack1, Err1=0.
  - Read returns RData1=8'h3C.
- Req1 write 0xA5 to offset 0x01 (default mask):
  - No WrDev_En is asserted.
  - Ack1 and Err1 pulse together.
  - A Req0 read of 0x01 returns 8'h55.
  - Req0 write to 0x01 succeeds.
- Req0 and Req1 held high continuously, FIXED_PRIO=0:
  - Grants alternate 0,1,0,1, starting with 0.
  - One Ack every 4 cycles.
  - With FIXED_PRIO=1, only Ack0 occurs.
- Req0 read of offset 0x25 -> RData0=8'hFF, Ack0 normal.
- MainReset asserted during the CAPT state of a read:
  - Enables drop immediately.
  - No Ack is issued.
  - RData0/1=8'hFF.
  - After release, a tie is granted to requester 0.

Source files
------------

// File: rtl/cpld_reg_arbiter.sv
// Two-requester arbiter for the CPLD register-map access port.
// One fixed 4-cycle transaction per grant (IDLE/ISSUE/CAPT/ACK), with BMC write protection.
module cpld_reg_arbiter #(
   parameter bit          FIXED_PRIO  = 1'b0,
   parameter logic [7:0]  IO_BASE_HI  = 8'h00,
   parameter logic [31:0] BMC_WP_MASK = 32'h0000_0012
) (
   input  logic        Mclk,
   input  logic        MainReset,
   input  logic        Req0,
   input  logic        Wr0,
   input  logic [7:0]  Addr0,
   input  logic [7:0]  WData0,
   output logic        Ack0,
   output logic [7:0]  RData0,
   input  logic        Req1,
   input  logic        Wr1,
   input  logic [7:0]  Addr1,
   input  logic [7:0]  WData1,
   output logic        Ack1,
   output logic [7:0]  RData1,
   output logic        Err1,
   output logic        Busy,
   output logic [15:0] DevAddr,
   output logic        RdDev_En,
   output logic        WrDev_En,
   output logic [7:0]  WrDev_Data,
   input  logic [7:0]  RdDev_Data
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_CAPT  = 2'd2,
      ST_ACK   = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_state_next;

   logic        r_gnt;
   logic        r_last_gnt;
   logic        r_wr;
   logic        r_err;

   logic        r_ack0;
   logic        r_ack1;
   logic        r_err1;
   logic        r_busy;
   logic [15:0] r_dev_addr;
   logic        r_rd_en;
   logic        r_wr_en;
   logic [7:0]  r_wr_data;
   logic [7:0]  r_rdata0;
   logic [7:0]  r_rdata1;

   logic        w_gnt_sel;
   logic        w_sel_wr;
   logic [7:0]  w_sel_addr;
   logic [7:0]  w_sel_wdata;
   logic        w_blocked;
   logic        w_load;

   logic        w_ack0_next;
   logic        w_ack1_next;
   logic        w_err1_next;
   logic        w_busy_next;
   logic [15:0] w_dev_addr_next;
   logic        w_rd_en_next;
   logic        w_wr_en_next;
   logic [7:0]  w_wr_data_next;
   logic [7:0]  w_rdata0_next;
   logic [7:0]  w_rdata1_next;

   // On a tie, fixed priority favours requester 0; otherwise grant whoever did not win last.
   always_comb begin
      if (Req0 && Req1) begin
         w_gnt_sel = FIXED_PRIO ? 1'b0 : ~r_last_gnt;
      end else begin
         w_gnt_sel = Req1;
      end
   end

   assign w_sel_wr    = w_gnt_sel ? Wr1    : Wr0;
   assign w_sel_addr  = w_gnt_sel ? Addr1  : Addr0;
   assign w_sel_wdata = w_gnt_sel ? WData1 : WData0;
   assign w_blocked   = w_gnt_sel && w_sel_wr && (w_sel_addr[7:5] == 3'b000)
                        && BMC_WP_MASK[w_sel_addr[4:0]];

   always_ff @(posedge Mclk or posedge MainReset) begin
      if (MainReset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next    = r_state;
      w_load          = 1'b0;
      w_ack0_next     = 1'b0;
      w_ack1_next     = 1'b0;
      w_err1_next     = 1'b0;
      w_busy_next     = 1'b1;
      w_dev_addr_next = r_dev_addr;
      w_rd_en_next    = 1'b0;
      w_wr_en_next    = 1'b0;
      w_wr_data_next  = r_wr_data;
      w_rdata0_next   = r_rdata0;
      w_rdata1_next   = r_rdata1;
      case (r_state)
         ST_IDLE: begin
            if (Req0 || Req1) begin
               w_state_next    = ST_ISSUE;
               w_load          = 1'b1;
               w_dev_addr_next = {IO_BASE_HI, w_sel_addr};
               if (!w_sel_wr) begin
                  w_rd_en_next = 1'b1;
               end else if (!w_blocked) begin
                  w_wr_en_next   = 1'b1;
                  w_wr_data_next = w_sel_wdata;
               end
            end else begin
               w_busy_next = 1'b0;
            end
         end
         ST_ISSUE: begin
            w_state_next = ST_CAPT;
         end
         ST_CAPT: begin
            // Read data from the map is valid now, one cycle after the enable.
            w_state_next = ST_ACK;
            if (!r_wr) begin
               if (r_gnt) begin
                  w_rdata1_next = RdDev_Data;
               end else begin
                  w_rdata0_next = RdDev_Data;
               end
            end
            w_ack0_next = ~r_gnt;
            w_ack1_next = r_gnt;
            w_err1_next = r_gnt && r_err;
         end
         ST_ACK: begin
            w_state_next = ST_IDLE;
            w_busy_next  = 1'b0;
         end
         default: begin
            w_state_next = ST_IDLE;
            w_busy_next  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge Mclk or posedge MainReset) begin
      if (MainReset) begin
         r_gnt      <= 1'b0;
         r_last_gnt <= 1'b1;
         r_wr       <= 1'b0;
         r_err      <= 1'b0;
      end else if (w_load) begin
         r_gnt      <= w_gnt_sel;
         r_last_gnt <= w_gnt_sel;
         r_wr       <= w_sel_wr;
         r_err      <= w_blocked;
      end else if (r_state == ST_ACK) begin
         r_err      <= 1'b0;
      end
   end

   always_ff @(posedge Mclk or posedge MainReset) begin
      if (MainReset) begin
         r_ack0     <= 1'b0;
         r_ack1     <= 1'b0;
         r_err1     <= 1'b0;
         r_busy     <= 1'b0;
         r_dev_addr <= {IO_BASE_HI, 8'h00};
         r_rd_en    <= 1'b0;
         r_wr_en    <= 1'b0;
         r_wr_data  <= 8'h00;
         r_rdata0   <= 8'hFF;
         r_rdata1   <= 8'hFF;
      end else begin
         r_ack0     <= w_ack0_next;
         r_ack1     <= w_ack1_next;
         r_err1     <= w_err1_next;
         r_busy     <= w_busy_next;
         r_dev_addr <= w_dev_addr_next;
         r_rd_en    <= w_rd_en_next;
         r_wr_en    <= w_wr_en_next;
         r_wr_data  <= w_wr_data_next;
         r_rdata0   <= w_rdata0_next;
         r_rdata1   <= w_rdata1_next;
      end
   end

   assign Ack0       = r_ack0;
   assign Ack1       = r_ack1;
   assign Err1       = r_err1;
   assign Busy       = r_busy;
   assign DevAddr    = r_dev_addr;
   assign RdDev_En   = r_rd_en;
   assign WrDev_En   = r_wr_en;
   assign WrDev_Data = r_wr_data;
   assign RData0     = r_rdata0;
   assign RData1     = r_rdata1;

endmodule
